// File: rtl/mem_port_arb.sv
// Shares the single-port unified memory between instruction fetch (IF) and load/store (LS).
// Latency: grant is combinational with the request; the response is returned MEM_LAT cycles after the grant.
// Backpressure: one access outstanding; LS has priority, IF is forced after STARVE_MAX denials; hold_flag_o stalls the pipeline while LS waits.
// Optional build macro: MEM_ARB_PERF_EN adds 32-bit grant/conflict event counters.
module mem_port_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  input  logic [3:0]        ls_wmask_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_wmask_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              hold_flag_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_gnt_o,
  output logic [31:0]       perf_ls_gnt_o,
  output logic [31:0]       perf_conflict_o
`endif
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t             state_q, state_d;
  owner_t             owner_q, owner_d;
  logic               is_write_q, is_write_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [STV_W-1:0]   starve_cnt_q, starve_cnt_d;

  logic arb_free;
  logic resp_now;
  logic if_gnt;
  logic ls_gnt;

  // Arbitration: free when idle or in the response cycle; LS wins a conflict unless IF has been starved.
  // Everything is gated by rst_n so all outputs read 0 during the reset cycle.
  always_comb begin
    arb_free = (state_q == IDLE) || ((state_q == BUSY) && (lat_cnt_q == LAT_ONE));
    if_gnt   = 1'b0;
    ls_gnt   = 1'b0;
    if (rst_n && arb_free) begin
      if (if_req_i && ls_req_i) begin
        if (starve_cnt_q == STV_MAX) begin
          if_gnt = 1'b1;
        end else begin
          ls_gnt = 1'b1;
        end
      end else begin
        if_gnt = if_req_i;
        ls_gnt = ls_req_i;
      end
    end
  end

  // Memory port mux: fields come from the granted requester, IF never writes, all zero when nothing is granted.
  always_comb begin
    mem_req_o   = if_gnt | ls_gnt;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (ls_gnt) begin
      mem_we_o    = ls_we_i;
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_wdata_i;
      mem_wmask_o = ls_wmask_i;
    end else if (if_gnt) begin
      mem_addr_o  = if_addr_i;
    end
  end

  // Response steering: the access completes in the cycle lat_cnt reaches 1; stores report completion with zero data.
  always_comb begin
    resp_now    = rst_n && (state_q == BUSY) && (lat_cnt_q == LAT_ONE);
    if_rvalid_o = resp_now && (owner_q == OWN_IF);
    ls_rvalid_o = resp_now && (owner_q == OWN_LS);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    ls_rdata_o  = (ls_rvalid_o && !is_write_q) ? mem_rdata_i : '0;
    if_gnt_o    = if_gnt;
    ls_gnt_o    = ls_gnt;
    hold_flag_o = rst_n && ls_req_i && !ls_gnt;
  end

  // Next-state logic: a grant (re)starts the latency count and captures the new owner,
  // even when it coincides with the previous access's response cycle.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    is_write_d = is_write_q;
    lat_cnt_d  = lat_cnt_q;
    if (if_gnt || ls_gnt) begin
      state_d    = BUSY;
      lat_cnt_d  = LAT_INIT;
      owner_d    = ls_gnt ? OWN_LS : OWN_IF;
      is_write_d = ls_gnt && ls_we_i;
    end else begin
      case (state_q)
        BUSY: begin
          if (lat_cnt_q == LAT_ONE) begin
            state_d   = IDLE;
            lat_cnt_d = '0;
          end else begin
            lat_cnt_d = lat_cnt_q - LAT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Starvation guard: counts cycles IF waits behind an LS grant; saturates so IF wins the next conflict.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt || !if_req_i) begin
      starve_cnt_d = '0;
    end else if (ls_gnt && (starve_cnt_q != STV_MAX)) begin
      starve_cnt_d = starve_cnt_q + STV_W'(1);
    end
  end

  // State registers with synchronous reset; an access in flight at reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      is_write_q   <= 1'b0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      is_write_q   <= is_write_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_gnt_q, perf_if_gnt_d;
  logic [31:0] perf_ls_gnt_q, perf_ls_gnt_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;

  // Event counters: wrap naturally at 2^32.
  always_comb begin
    perf_if_gnt_d   = perf_if_gnt_q + {31'd0, if_gnt};
    perf_ls_gnt_d   = perf_ls_gnt_q + {31'd0, ls_gnt};
    perf_conflict_d = perf_conflict_q + {31'd0, (arb_free && if_req_i && ls_req_i)};
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_if_gnt_q   <= '0;
      perf_ls_gnt_q   <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_if_gnt_q   <= perf_if_gnt_d;
      perf_ls_gnt_q   <= perf_ls_gnt_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_if_gnt_o   = perf_if_gnt_q;
  assign perf_ls_gnt_o   = perf_ls_gnt_q;
  assign perf_conflict_o = perf_conflict_q;
`endif

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Arbiter/sequencer that shares the core's single-port unified memory between two requesters: instruction fetch (IF) and load/store (LS).
- Sits between the fetch unit / execute unit and the memory block.
- Allows one outstanding access at a time, with fixed read latency, and supports back-to-back issue.
- Gives LS priority, with a starvation guard for IF, and raises a hold flag to pipeline control while an LS request waits.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from accepted memory request to mem_rdata_i valid; legal range ≥1
- STARVE_MAX, 4, number of consecutive cycles IF may be denied while requesting before IF gets forced priority; legal range ≥1

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_req_i  in  1  fetch request
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  DATA_W  fetch data
- ls_req_i  in  1  load/store request
- ls_we_i  in  1  1 = store
- ls_addr_i  in  ADDR_W  load/store address
- ls_wdata_i  in  DATA_W  store data
- ls_wmask_i  in  4  byte write mask
- ls_gnt_o  out  1  LS request accepted this cycle
- ls_rvalid_o  out  1  load data valid, or store completion
- ls_rdata_o  out  DATA_W  load data; 0 for stores
- mem_req_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_wmask_o  out  4  memory byte mask
- mem_rdata_i  in  DATA_W  memory read data, valid MEM_LAT cycles after the request
- hold_flag_o  out  1  LS request pending but not granted; stall request to pipeline control

Behaviour:
- Clock and reset: single clock domain. All state resets synchronously when rst_n=0 at a clk edge.
- State machine: IDLE, BUSY.
  - Registers: owner (IF/LS), is_write, lat_cnt, starve_cnt.
- Arbiter free: arb_free = (state==IDLE) OR (state==BUSY AND lat_cnt==1). The second term allows issue in the same cycle the previous response returns, so back-to-back throughput is one access per MEM_LAT cycles.
- Grant (combinational, same cycle as request):
  - If arb_free and only one requester is active, that requester is granted.
  - If both are active, LS wins unless starve_cnt==STARVE_MAX, in which case IF wins.
  - At most one grant is asserted per cycle.
- Memory drive:
  - mem_req_o = if_gnt_o | ls_gnt_o.
  - mem_* fields are muxed from the granted requester.
  - If IF is granted: mem_we_o=0, mem_wmask_o=0.
  - If nothing is granted: all mem_* outputs are 0.
- On grant:
  - state←BUSY, lat_cnt←MEM_LAT.
  - owner and is_write are captured.
- In BUSY:
  - lat_cnt decrements each cycle.
  - When lat_cnt==1, the response is delivered combinationally:
    - owner IF → if_rvalid_o=1, if_rdata_o=mem_rdata_i.
    - owner LS → ls_rvalid_o=1, ls_rdata_o = is_write ? 0 : mem_rdata_i.
  - In that same cycle, if no new grant occurs, next state is IDLE.
- rdata outputs are 0 whenever the matching rvalid is 0.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle that if_req_i=1 and ls_gnt_o=1.
  - Clears on if_gnt_o, or when if_req_i=0.
  - Holds otherwise.
- hold_flag_o = ls_req_i & ~ls_gnt_o.
- Requesters must hold req and its payload stable until granted. A request dropped before grant is simply not serviced.
- Reset values: state=IDLE, lat_cnt=0, starve_cnt=0, owner=IF, is_write=0. All outputs are 0 while rst_n=0.
- Reset mid-operation: the outstanding access is abandoned, and no rvalid is produced for it after reset deasserts.
- Simultaneous response and new grant: the response pulse goes to the old owner, and owner updates to the new requester on the same edge.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_if_gnt_o, perf_ls_gnt_o and perf_conflict_o, each 32 bit.
  - Each counter increments on if_gnt_o, on ls_gnt_o, or on a cycle where both requests are active while arb_free, respectively.
  - Counters wrap at 2^32 and are synchronously reset to 0.
- Undefined: these ports and registers are absent. Functional behaviour is identical in both cases.

Test Plan:
- Lone fetch, MEM_LAT=1: if_req_i=1, if_addr_i=0x100 → if_gnt_o=1 in cycle 0, mem_addr_o=0x100; next cycle if_rvalid_o=1 with if_rdata_o=mem_rdata_i.
- Conflict: if_req_i=1 and ls_req_i=1 (load 0x2000) in the same cycle → ls_gnt_o=1, if_gnt_o=0; IF is granted on the following free cycle.
- Starvation, STARVE_MAX=4: both requests held high, LS re-requesting each cycle → LS wins 4 consecutive grants, the 5th grant goes to IF, and starve_cnt returns to 0.
- Store: ls_we_i=1, ls_wmask_i=4'b0011, ls_wdata_i=0xDEADBEEF → mem_we_o=1, mem_wmask_o=4'b0011; MEM_LAT cycles later ls_rvalid_o=1 and ls_rdata_o=0.
- MEM_LAT=3, LS request arrives while BUSY with lat_cnt=3 → hold_flag_o=1 for 2 cycles, then grant in the response cycle of the prior access with no idle gap.
- Reset while BUSY (lat_cnt=2): hold rst_n=0 for 1 cycle → no rvalid afterwards, state=IDLE, all outputs 0.
